// File: rtl/matrix_result_serializer.sv
// matrix_result_serializer
//   Captures one N x N signed result matrix on a rising edge of load.
//   Requantizes each element (arithmetic right shift by SHIFT, then saturate to OUT_W).
//   Streams the elements row-major over a valid/ready handshake.
//
// Optional feature macro: MRS_RELU_EN
//   When defined, negative values output 0, and only positive overflow saturates.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        asynchronous, active-high reset
//   load       capture request, acted on at its rising edge only
//   c_in       N x N matrix of IN_W-bit signed elements, c_in[row][col]
//   busy       high while streaming and during the done cycle
//   out_data   requantized element
//   out_valid  out_data valid
//   out_ready  consumer accepts when out_valid & out_ready
//   out_row    row index of out_data
//   out_col    column index of out_data
//   out_last   high with element (N-1, N-1)
//   done       one-cycle pulse after the last element is accepted
//   sat_cnt    number of saturated elements accepted from the current matrix
module matrix_result_serializer #(
    parameter int N     = 4,
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load,
    input  logic [N-1:0][N-1:0][IN_W-1:0]     c_in,
    output logic                              busy,
    output logic [OUT_W-1:0]                  out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(N)-1:0]              out_row,
    output logic [$clog2(N)-1:0]              out_col,
    output logic                              out_last,
    output logic                              done,
    output logic [$clog2(N*N):0]              sat_cnt
);

    localparam int IW = $clog2(N);
    localparam int SW = $clog2(N*N) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    // Representable OUT_W range, expressed at IN_W width for comparison with v.
    localparam logic signed [IN_W-1:0] VMAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
`ifndef MRS_RELU_EN
    localparam logic signed [IN_W-1:0] VMIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic                          load_q;
    logic [IW-1:0]                 row_q, row_d;
    logic [IW-1:0]                 col_q, col_d;
    logic [SW-1:0]                 sat_q, sat_d;
    logic [N-1:0][N-1:0][IN_W-1:0] buf_q;
    logic                          capture;

    logic signed [IN_W-1:0]        elem;
    logic signed [IN_W-1:0]        v;
    logic [OUT_W-1:0]              q;
    logic                          sat;

    // Requantization of the element currently addressed by row_q/col_q.
    always_comb begin
        elem = buf_q[row_q][col_q];
        v    = elem >>> SHIFT;
        q    = v[OUT_W-1:0];
        sat  = 1'b0;
`ifdef MRS_RELU_EN
        if (v[IN_W-1]) begin
            q = '0;
        end else if (v > VMAX) begin
            q   = {1'b0, {(OUT_W-1){1'b1}}};
            sat = 1'b1;
        end
`else
        if (v > VMAX) begin
            q   = {1'b0, {(OUT_W-1){1'b1}}};
            sat = 1'b1;
        end else if (v < VMIN) begin
            q   = {1'b1, {(OUT_W-1){1'b0}}};
            sat = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        sat_d     = sat_q;
        capture   = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load & ~load_q) begin
                    capture = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    sat_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = q;
                out_last  = (row_q == LAST_IDX) && (col_q == LAST_IDX);
                if (out_ready) begin
                    if (sat) sat_d = sat_q + 1'b1;
                    if (out_last) begin
                        state_d = S_DONE;
                    end else if (col_q == LAST_IDX) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_row = row_q;
    assign out_col = col_q;
    assign sat_cnt = sat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            load_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load;
            row_q   <= row_d;
            col_q   <= col_d;
            sat_q   <= sat_d;
        end
    end

    // Capture buffer needs no reset; it is only read while streaming.
    always_ff @(posedge clk) begin
        if (capture) buf_q <= c_in;
    end

endmodule

// File: tb/tb_matrix_result_serializer.sv
module tb_matrix_result_serializer;

    localparam int N     = 4;
    localparam int IN_W  = 16;
    localparam int OUT_W = 8;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          load;
    logic [N-1:0][N-1:0][IN_W-1:0] c_in;
    logic                          out_ready;

    logic                          busy, out_valid, out_last, done;
    logic [OUT_W-1:0]              out_data;
    logic [1:0]                    out_row, out_col;
    logic [4:0]                    sat_cnt;

    logic                          d2_busy, d2_valid, d2_last, d2_done;
    logic [OUT_W-1:0]              d2_data;
    logic [1:0]                    d2_row, d2_col;
    logic [4:0]                    d2_sat;

    matrix_result_serializer #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .load(load), .c_in(c_in),
        .busy(busy), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .done(done),
        .sat_cnt(sat_cnt)
    );

    matrix_result_serializer #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(2)) dut_sh2 (
        .clk(clk), .rst(rst), .load(load), .c_in(c_in),
        .busy(d2_busy), .out_data(d2_data), .out_valid(d2_valid), .out_ready(out_ready),
        .out_row(d2_row), .out_col(d2_col), .out_last(d2_last), .done(d2_done),
        .sat_cnt(d2_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] c;
        logic signed [7:0]  e;
        bit                 s;
    } vec_t;

    vec_t tab [48];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_c(input int base);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                c_in[i][j] = tab[base + i*N + j].c;
    endtask

    // mode 0: ready always; 1: ready every third cycle; 2: load held high with a
    // glitch at beat 6 and c_in scrambled after capture; 3: reset at beat 5.
    task automatic run(input int base, input int mode);
        int k = 0, donec = 0, expsat = 0;
        bit prev_v = 0, prev_r = 0, exp_done = 0, aborted = 0, glitched = 0, rdy;
        logic [7:0] pd;
        logic [1:0] pr, pc;
        logic pl;
        for (int i = 0; i < 16; i++) expsat += int'(tab[base + i].s);
        @(negedge clk);
        set_c(base);
        load = 1'b1;
        out_ready = (mode == 1) ? 1'b0 : 1'b1;
        @(negedge clk);
        chk("valid_latency", out_valid, 1);
        chk("busy_on", busy, 1);
        if (mode != 2) load = 1'b0;
        else c_in = {N*N{16'h0055}};
        for (int cyc = 0; cyc < 70; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (rst) rst = 1'b0;
            if (mode == 2) begin
                if (k == 6 && !glitched) begin
                    load = 1'b0;
                    glitched = 1;
                end else load = (cyc < 40);
            end
            if (done) donec++;
            if (exp_done) begin
                chk("done_after_last", done, 1);
                chk("valid_in_done", out_valid, 0);
                exp_done = 0;
            end
            if (out_valid && prev_v && !prev_r) begin
                chk("stall_data", out_data, pd);
                chk("stall_row", out_row, pr);
                chk("stall_col", out_col, pc);
                chk("stall_last", out_last, pl);
            end
            if (mode == 3 && k == 5 && !aborted) begin
                rst = 1'b1;
                #1;
                chk("rst_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_row", out_row, 0);
                chk("rst_col", out_col, 0);
                chk("rst_data", out_data, 0);
                aborted = 1;
                prev_v = 0;
                continue;
            end
            if (out_valid) begin
                rdy = (mode == 1) ? (cyc % 3 == 2) : 1'b1;
                out_ready = rdy;
                if (rdy) begin
                    if (k < 16) begin
                        chk("beat_data", $signed(out_data), tab[base + k].e);
                        chk("beat_row", out_row, k / 4);
                        chk("beat_col", out_col, k % 4);
                        chk("beat_last", out_last, (k == 15));
                        if (base == 16 && mode == 0 && k == 0)
                            chk("shift2_data", $signed(d2_data), 75);
                    end
                    k++;
                    if (k == 16) exp_done = 1;
                end
            end else begin
                out_ready = (mode == 1) ? 1'b0 : 1'b1;
            end
            prev_v = out_valid;
            prev_r = out_ready;
            pd = out_data;
            pr = out_row;
            pc = out_col;
            pl = out_last;
        end
        load = 1'b0;
        chk("beat_count", k, (mode == 3) ? 5 : 16);
        chk("done_count", donec, (mode == 3) ? 0 : 1);
        chk("sat_cnt", sat_cnt, (mode == 3) ? 0 : expsat);
        chk("busy_idle", busy, 0);
        if (base == 16 && mode == 0) chk("shift2_sat", d2_sat, 1);
    endtask

    initial begin
        // Matrix A: i*4+j-8
        for (int k = 0; k < 16; k++) begin
            tab[k].c = 16'(k - 8);
`ifdef MRS_RELU_EN
            tab[k].e = (k < 8) ? 8'sd0 : 8'(k - 8);
`else
            tab[k].e = 8'(k - 8);
`endif
            tab[k].s = 0;
        end
        // Matrix B: saturation corners, rest 1
        for (int k = 16; k < 32; k++) begin
            tab[k].c = 16'sd1;
            tab[k].e = 8'sd1;
            tab[k].s = 0;
        end
        tab[16] = '{16'sd300, 8'sd127, 1'b1};
`ifdef MRS_RELU_EN
        tab[17] = '{-16'sd300, 8'sd0, 1'b0};
`else
        tab[17] = '{-16'sd300, -8'sd128, 1'b1};
`endif
        tab[20] = '{16'sh7FFF, 8'sd127, 1'b1};
        // Matrix C: -5, 200, 12, then 3..15
        for (int k = 32; k < 48; k++) begin
            tab[k].c = 16'(k - 32);
            tab[k].e = 8'(k - 32);
            tab[k].s = 0;
        end
`ifdef MRS_RELU_EN
        tab[32] = '{-16'sd5, 8'sd0, 1'b0};
`else
        tab[32] = '{-16'sd5, -8'sd5, 1'b0};
`endif
        tab[33] = '{16'sd200, 8'sd127, 1'b1};
        tab[34] = '{16'sd12, 8'sd12, 1'b0};

        rst = 1'b1;
        load = 1'b0;
        out_ready = 1'b0;
        c_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_row", out_row, 0);
        chk("reset_col", out_col, 0);
        chk("reset_last", out_last, 0);
        chk("reset_done", done, 0);
        chk("reset_sat", sat_cnt, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready_no_valid", out_valid, 0);

        run(0, 0);
        run(0, 1);
        run(16, 0);
        run(0, 2);
        run(16, 3);
        run(32, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
